// File: rtl/conv_block_scheduler.sv
// -----------------------------------------------------------------------------
// conv_block_scheduler
//
// Top-level sequencer for the column-block address FSM of the 2D convolution
// core. Walks an image one column block at a time: reset/configure the FSM,
// load the block, process it, read it back, then advance to the next block.
// Host strobes (run/abort/data valid) are turned into the FSM's reset, load,
// start-of-process and valid inputs; status goes back to the host registers.
//
// Optional build macro: SCHED_WATCHDOG_EN
//   Adds a 16-bit per-phase watchdog. If LOAD/PROC/PWAIT/READ sits for
//   WDT_CYCLES cycles without an i_changeBlock or i_EoP rise, o_error is set
//   and the abort sequence is applied.
//
// Ports:
//   i_CLK          clock
//   i_reset        asynchronous active-low reset
//   i_run          host start level, rising edge starts an image
//   i_abort        synchronous abort, active-high
//   i_imgLength    image height, latched at start and forwarded to the FSM
//   i_imgWidth     image width, block count = width - 2
//   i_hostValid    host data strobe for load/readback words
//   i_changeBlock  FSM: block load/process/read finished
//   i_EoP          FSM: end of process
//   o_fsmReset     one-cycle synchronous reset pulse to the FSM
//   o_imgLength    latched image height
//   o_load         FSM load request
//   o_SoP          FSM start-of-process
//   o_valid        host strobe gated by o_hostReady (combinational)
//   o_hostReady    scheduler accepts host strobes
//   o_blockIdx     current block index
//   o_busy         scheduler not idle
//   o_done         one-cycle pulse at image end
//   o_error        sticky error flag
// -----------------------------------------------------------------------------
module conv_block_scheduler #(
    parameter int NB_IMAGE   = 10,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_abort,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_IMAGE-1:0] i_imgWidth,
    input  logic                i_hostValid,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    output logic                o_fsmReset,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic                o_hostReady,
    output logic [NB_IMAGE-1:0] o_blockIdx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_LOAD,
        S_GAP,
        S_PROC,
        S_PWAIT,
        S_READ,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [NB_IMAGE-1:0] MIN_SIZE = NB_IMAGE'(3);

    state_t state, next_state;

    logic run_q, cb_q;
    logic run_rise, cb_rise;
    logic sizes_ok;
    logic wdt_trip;
    logic abort_req;

    logic [NB_IMAGE-1:0] width_q;

    // Next values of the registered outputs and latched sizes.
    logic                fsm_reset_d, load_d, sop_d, ready_d, done_d, error_d;
    logic [NB_IMAGE-1:0] length_d, width_d, blk_idx_d;

    assign run_rise  = i_run & ~run_q;
    assign cb_rise   = i_changeBlock & ~cb_q;
    assign sizes_ok  = (i_imgLength >= MIN_SIZE) && (i_imgWidth >= MIN_SIZE);
    assign abort_req = i_abort | wdt_trip;

    assign o_valid = i_hostValid & o_hostReady;

`ifdef SCHED_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

    logic [15:0] wdt_cnt;
    logic        eop_q;
    logic        eop_rise;

    assign eop_rise = i_EoP & ~eop_q;

    function automatic logic watched(input state_t s);
        return (s == S_LOAD) || (s == S_PROC) || (s == S_PWAIT) || (s == S_READ);
    endfunction

    // Fires on the cycle whose increment would bring the count to WDT_CYCLES,
    // so the error and the return to IDLE land on that same edge.
    assign wdt_trip = watched(state) && !cb_rise && !eop_rise && (wdt_cnt == WDT_LAST);

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            wdt_cnt <= '0;
            eop_q   <= 1'b0;
        end else begin
            eop_q <= i_EoP;
            if (watched(next_state) && ((next_state != state) || cb_rise || eop_rise))
                wdt_cnt <= '0;
            else if (watched(state))
                wdt_cnt <= wdt_cnt + 16'd1;
        end
    end
`else
    logic [31:0] unused_wdt_cycles;

    assign wdt_trip          = 1'b0;
    assign unused_wdt_cycles = 32'(WDT_CYCLES);
`endif

    // NOTE: every variable assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state  = state;
        fsm_reset_d = 1'b0;
        done_d      = 1'b0;
        load_d      = o_load;
        sop_d       = o_SoP;
        ready_d     = o_hostReady;
        error_d     = o_error;
        length_d    = o_imgLength;
        width_d     = width_q;
        blk_idx_d   = o_blockIdx;

        case (state)
            S_IDLE: begin
                // Abort in IDLE suppresses a coincident start.
                if (run_rise && !i_abort) begin
                    if (sizes_ok) begin
                        length_d    = i_imgLength;
                        width_d     = i_imgWidth;
                        error_d     = 1'b0;
                        blk_idx_d   = '0;
                        fsm_reset_d = 1'b1;
                        next_state  = S_CFG;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_CFG: begin
                load_d     = 1'b1;
                ready_d    = 1'b1;
                next_state = S_LOAD;
            end
            S_LOAD: begin
                if (cb_rise) begin
                    load_d     = 1'b0;
                    ready_d    = 1'b0;
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                // Let the FSM drop i_changeBlock before the next phase starts.
                if (!i_changeBlock) begin
                    sop_d      = 1'b1;
                    next_state = S_PROC;
                end
            end
            S_PROC: begin
                if (cb_rise) next_state = S_PWAIT;
            end
            S_PWAIT: begin
                if (i_EoP) begin
                    sop_d      = 1'b0;
                    ready_d    = 1'b1;
                    next_state = S_READ;
                end
            end
            S_READ: begin
                if (cb_rise) begin
                    ready_d    = 1'b0;
                    next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (o_blockIdx == width_q - MIN_SIZE) begin
                    done_d     = 1'b1;
                    next_state = S_DONE;
                end else begin
                    blk_idx_d   = o_blockIdx + NB_IMAGE'(1);
                    fsm_reset_d = 1'b1;
                    next_state  = S_CFG;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Abort (host or watchdog) overrides whatever the phase logic decided.
        if (abort_req && (state != S_IDLE)) begin
            load_d      = 1'b0;
            sop_d       = 1'b0;
            ready_d     = 1'b0;
            done_d      = 1'b0;
            fsm_reset_d = 1'b1;
            blk_idx_d   = o_blockIdx;
            next_state  = S_IDLE;
        end
        if (wdt_trip) error_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            run_q       <= 1'b0;
            cb_q        <= 1'b0;
            width_q     <= '0;
            o_fsmReset  <= 1'b0;
            o_imgLength <= '0;
            o_load      <= 1'b0;
            o_SoP       <= 1'b0;
            o_hostReady <= 1'b0;
            o_blockIdx  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            run_q       <= i_run;
            cb_q        <= i_changeBlock;
            width_q     <= width_d;
            o_fsmReset  <= fsm_reset_d;
            o_imgLength <= length_d;
            o_load      <= load_d;
            o_SoP       <= sop_d;
            o_hostReady <= ready_d;
            o_blockIdx  <= blk_idx_d;
            // Registered from next_state so it lines up with the state register.
            o_busy      <= (next_state != S_IDLE);
            o_done      <= done_d;
            o_error     <= error_d;
        end
    end

endmodule

// File: tb/tb_conv_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_block_scheduler
//
// Directed self-checking bench for conv_block_scheduler. A small model of the
// column-block FSM answers each phase after 10 cycles. Outputs are sampled on
// the falling clock edge; inputs are driven there too.
// Build with SCHED_WATCHDOG_EN defined to add the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_conv_block_scheduler;

    localparam int NB  = 10;
    localparam int WDT = 64;

    localparam int SIG_RST   = 0;
    localparam int SIG_LOAD  = 1;
    localparam int SIG_SOP   = 2;
    localparam int SIG_READY = 3;
    localparam int SIG_DONE  = 4;

    logic          i_CLK = 1'b0;
    logic          i_reset;
    logic          i_run, i_abort, i_hostValid, i_changeBlock, i_EoP;
    logic [NB-1:0] i_imgLength, i_imgWidth;
    logic          o_fsmReset, o_load, o_SoP, o_valid, o_hostReady;
    logic          o_busy, o_done, o_error;
    logic [NB-1:0] o_imgLength, o_blockIdx;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_rst  = 0;
    int n_done = 0;

    conv_block_scheduler #(.NB_IMAGE(NB), .WDT_CYCLES(WDT)) dut (
        .i_CLK        (i_CLK),
        .i_reset      (i_reset),
        .i_run        (i_run),
        .i_abort      (i_abort),
        .i_imgLength  (i_imgLength),
        .i_imgWidth   (i_imgWidth),
        .i_hostValid  (i_hostValid),
        .i_changeBlock(i_changeBlock),
        .i_EoP        (i_EoP),
        .o_fsmReset   (o_fsmReset),
        .o_imgLength  (o_imgLength),
        .o_load       (o_load),
        .o_SoP        (o_SoP),
        .o_valid      (o_valid),
        .o_hostReady  (o_hostReady),
        .o_blockIdx   (o_blockIdx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_CLK = ~i_CLK;

    // Pulse counters: each posedge counts the level held over the prior cycle.
    always @(posedge i_CLK) begin
        if (o_fsmReset) n_rst++;
        if (o_done)     n_done++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic sig_val(input int which);
        case (which)
            SIG_RST:   return o_fsmReset;
            SIG_LOAD:  return o_load;
            SIG_SOP:   return o_SoP;
            SIG_READY: return o_hostReady;
            default:   return o_done;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget);
        int seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_CLK);
            if (sig_val(which) === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check(tag, seen, 1);
    endtask

    task automatic pulse_cb();
        i_changeBlock = 1'b1;
        @(negedge i_CLK);
        i_changeBlock = 1'b0;
    endtask

    // One full block as the FSM model sees it. vchk adds o_valid gating checks.
    task automatic do_block(input int idx, input bit vchk);
        wait_for("cfg_pulse", SIG_RST, 50);
        wait_for("load_on", SIG_LOAD, 50);
        check("blk_idx", int'(o_blockIdx), idx);
        if (vchk) begin
            i_hostValid = 1'b1; #1;
            check("valid_load_hi", int'(o_valid), 1);
            i_hostValid = 1'b0; #1;
            check("valid_load_lo", int'(o_valid), 0);
        end
        repeat (10) @(negedge i_CLK);
        pulse_cb();                                   // now in GAP
        check("load_off", int'(o_load), 0);
        if (vchk) begin
            i_hostValid = 1'b1; #1;
            check("valid_gap", int'(o_valid), 0);
            i_hostValid = 1'b0;
        end
        wait_for("sop_on", SIG_SOP, 50);
        repeat (10) @(negedge i_CLK);
        pulse_cb();                                   // now in PWAIT
        check("sop_hold", int'(o_SoP), 1);
        if (vchk) begin
            i_hostValid = 1'b1; #1;
            check("valid_pwait", int'(o_valid), 0);
            i_hostValid = 1'b0;
        end
        repeat (10) @(negedge i_CLK);
        i_EoP = 1'b1;
        @(negedge i_CLK);
        i_EoP = 1'b0;                                 // now in READ
        check("sop_off", int'(o_SoP), 0);
        wait_for("read_ready", SIG_READY, 5);
        if (vchk) begin
            i_hostValid = 1'b1; #1;
            check("valid_read", int'(o_valid), 1);
            i_hostValid = 1'b0;
        end
        repeat (10) @(negedge i_CLK);
        pulse_cb();                                   // now in NEXT
    endtask

    int r0, d0, cnt;

    initial begin
        i_reset = 1'b0;
        i_run = 1'b0; i_abort = 1'b0; i_hostValid = 1'b0;
        i_changeBlock = 1'b0; i_EoP = 1'b0;
        i_imgLength = NB'(8); i_imgWidth = NB'(5);

        // Reset state
        repeat (3) @(negedge i_CLK);
        i_reset = 1'b1;
        @(negedge i_CLK);
        check("rst_busy", int'(o_busy), 0);
        check("rst_fsmreset", int'(o_fsmReset), 0);
        check("rst_load", int'(o_load), 0);
        check("rst_sop", int'(o_SoP), 0);
        check("rst_ready", int'(o_hostReady), 0);
        check("rst_idx", int'(o_blockIdx), 0);
        check("rst_error", int'(o_error), 0);
        check("rst_len", int'(o_imgLength), 0);
        i_hostValid = 1'b1; #1;
        check("rst_valid", int'(o_valid), 0);
        i_hostValid = 1'b0;

        // Image 8x5: three blocks; sizes changed mid-image must be ignored
        r0 = n_rst; d0 = n_done;
        i_run = 1'b1;
        do_block(0, 1'b1);
        i_run = 1'b0;
        i_imgLength = NB'(3); i_imgWidth = NB'(9);
        check("len_latched", int'(o_imgLength), 8);
        do_block(1, 1'b0);
        do_block(2, 1'b0);
        wait_for("done_pulse", SIG_DONE, 5);
        @(negedge i_CLK);
        check("img1_done_off", int'(o_done), 0);
        check("img1_busy", int'(o_busy), 0);
        check("img1_idx", int'(o_blockIdx), 2);
        check("img1_rst_cnt", n_rst - r0, 3);
        check("img1_done_cnt", n_done - d0, 1);

        // Width 2 rejected, then width 4 runs two blocks
        r0 = n_rst; d0 = n_done;
        i_imgLength = NB'(8); i_imgWidth = NB'(2);
        i_run = 1'b1;
        repeat (2) @(negedge i_CLK);
        check("bad_error", int'(o_error), 1);
        check("bad_busy", int'(o_busy), 0);
        check("bad_rst_cnt", n_rst - r0, 0);
        i_run = 1'b0; i_imgWidth = NB'(4);
        @(negedge i_CLK);
        i_run = 1'b1;
        do_block(0, 1'b0);
        check("err_cleared", int'(o_error), 0);
        i_run = 1'b0;
        do_block(1, 1'b0);
        wait_for("img2_done", SIG_DONE, 5);
        @(negedge i_CLK);
        check("img2_busy", int'(o_busy), 0);
        check("img2_rst_cnt", n_rst - r0, 2);
        check("img2_done_cnt", n_done - d0, 1);

        // Abort during PROC of block 1
        r0 = n_rst; d0 = n_done;
        i_imgWidth = NB'(5);
        i_run = 1'b1;
        do_block(0, 1'b0);
        i_run = 1'b0;
        wait_for("ab_cfg", SIG_RST, 50);
        wait_for("ab_load", SIG_LOAD, 50);
        repeat (10) @(negedge i_CLK);
        pulse_cb();
        wait_for("ab_sop", SIG_SOP, 50);
        i_abort = 1'b1;
        @(negedge i_CLK);
        i_abort = 1'b0;
        check("ab_sop_off", int'(o_SoP), 0);
        check("ab_fsmreset", int'(o_fsmReset), 1);
        check("ab_busy", int'(o_busy), 0);
        check("ab_ready", int'(o_hostReady), 0);
        check("ab_idx", int'(o_blockIdx), 1);
        @(negedge i_CLK);
        check("ab_fsmreset_off", int'(o_fsmReset), 0);
        check("ab_rst_cnt", n_rst - r0, 3);
        check("ab_done_cnt", n_done - d0, 0);
        check("ab_error", int'(o_error), 0);

        // Abort in IDLE coinciding with a run rise: no start
        r0 = n_rst;
        i_run = 1'b1; i_abort = 1'b1;
        @(negedge i_CLK);
        i_abort = 1'b0;
        @(negedge i_CLK);
        check("idle_ab_busy", int'(o_busy), 0);
        check("idle_ab_rst_cnt", n_rst - r0, 0);
        i_run = 1'b0;
        @(negedge i_CLK);

`ifdef SCHED_WATCHDOG_EN
        // FSM model never answers LOAD: watchdog trips WDT cycles after entry
        i_run = 1'b1;
        wait_for("wd_cfg", SIG_RST, 50);
        wait_for("wd_load", SIG_LOAD, 50);
        i_run = 1'b0;
        cnt = 0;
        while (o_error !== 1'b1 && cnt < 200) begin
            @(negedge i_CLK);
            cnt++;
        end
        check("wd_cycles", cnt, WDT);
        check("wd_busy", int'(o_busy), 0);
        check("wd_load_off", int'(o_load), 0);
        check("wd_fsmreset", int'(o_fsmReset), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
